// File: rtl/name_entry_ctrl_pkg.sv
// rtl/name_entry_ctrl_pkg.sv - shared constants and state type for player-name entry
package name_entry_ctrl_pkg;

  localparam int CHAR_W      = 5;
  localparam int NUM_CHARS   = 3;
  localparam int STRING_SIZE = NUM_CHARS * CHAR_W;

  localparam logic [CHAR_W-1:0] CHAR_A   = 5'd0;
  localparam logic [CHAR_W-1:0] CHAR_MAX = 5'd25;

  // Cursor: 0..NUM_CHARS-1 select a character, POS_CONFIRM boxes the whole name
  localparam int                POS_W       = 2;
  localparam logic [POS_W-1:0]  POS_FIRST   = 2'd0;
  localparam logic [POS_W-1:0]  POS_LAST    = 2'(NUM_CHARS - 1);
  localparam logic [POS_W-1:0]  POS_CONFIRM = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EDIT    = 2'd1,
    CONFIRM = 2'd2,
    COMMIT  = 2'd3
  } name_state_t;

endpackage

// File: rtl/name_entry_ctrl.sv
// rtl/name_entry_ctrl.sv - button-driven 3-character name entry with timeout and commit handshake
module name_entry_ctrl
  import name_entry_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_enter,
  input  logic                   commit_ack,
  output logic [STRING_SIZE-1:0] player_name,
  output logic [POS_W-1:0]       input_pos,
  output logic                   active,
  output logic                   commit_req,
  output logic                   done
);

  localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef logic [NUM_CHARS-1:0][CHAR_W-1:0] name_arr_t;

  name_state_t      state_q, state_d;
  name_arr_t        ch_q, ch_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             commit_req_q, commit_req_d;
  logic             done_q, done_d;
  logic             any_btn;

  // Z wraps to A going up, A wraps to Z going down
  function automatic logic [CHAR_W-1:0] char_inc(input logic [CHAR_W-1:0] c);
    return (c == CHAR_MAX) ? CHAR_A : c + CHAR_W'(1);
  endfunction

  function automatic logic [CHAR_W-1:0] char_dec(input logic [CHAR_W-1:0] c);
    return (c == CHAR_A) ? CHAR_MAX : c - CHAR_W'(1);
  endfunction

  assign any_btn = btn_up | btn_down | btn_left | btn_right | btn_enter;

  // Next-state, cursor, character edits and idle-timeout counting
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    pos_d        = pos_q;
    cnt_d        = '0;
    active_d     = active_q;
    commit_req_d = commit_req_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = EDIT;
          ch_d     = '0;
          pos_d    = POS_FIRST;
          active_d = 1'b1;
        end
      end

      EDIT: begin
        cnt_d = any_btn ? '0 : cnt_q + CNT_W'(1);
        if (btn_enter || btn_right) begin
          if (pos_q == POS_LAST) begin
            state_d = CONFIRM;
            pos_d   = POS_CONFIRM;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else if (btn_left) begin
          if (pos_q != POS_FIRST) pos_d = pos_q - POS_W'(1);
        end else if (btn_up) begin
          ch_d[pos_q] = char_inc(ch_q[pos_q]);
        end else if (btn_down) begin
          ch_d[pos_q] = char_dec(ch_q[pos_q]);
        end else if (cnt_q == CNT_LAST) begin
          state_d      = COMMIT;
          pos_d        = POS_CONFIRM;
          commit_req_d = 1'b1;
          cnt_d        = '0;
        end
      end

      CONFIRM: begin
        cnt_d = any_btn ? '0 : cnt_q + CNT_W'(1);
        if (btn_enter || (!any_btn && cnt_q == CNT_LAST)) begin
          state_d      = COMMIT;
          commit_req_d = 1'b1;
          cnt_d        = '0;
        end else if (btn_left) begin
          state_d = EDIT;
          pos_d   = POS_LAST;
        end
      end

      COMMIT: begin
        if (commit_ack) begin
          state_d      = IDLE;
          commit_req_d = 1'b0;
          done_d       = 1'b1;
          active_d     = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      pos_q        <= POS_FIRST;
      cnt_q        <= '0;
      active_q     <= 1'b0;
      commit_req_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      pos_q        <= pos_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      commit_req_q <= commit_req_d;
      done_q       <= done_d;
    end
  end

  // Flatten characters with ch[0] in the MSBs
  always_comb begin
    player_name = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      player_name[(NUM_CHARS-1-i)*CHAR_W +: CHAR_W] = ch_q[i];
    end
  end

  assign input_pos  = pos_q;
  assign active     = active_q;
  assign commit_req = commit_req_q;
  assign done       = done_q;

endmodule

// File: tb/tb_name_entry_ctrl.sv
// tb/tb_name_entry_ctrl.sv - self-checking bench for name_entry_ctrl
module tb_name_entry_ctrl;

  localparam int TO = 16;

  // Stimulus mask bits: {start, up, down, left, right, enter, ack}
  localparam logic [6:0] S = 7'b1000000;
  localparam logic [6:0] U = 7'b0100000;
  localparam logic [6:0] D = 7'b0010000;
  localparam logic [6:0] L = 7'b0001000;
  localparam logic [6:0] R = 7'b0000100;
  localparam logic [6:0] E = 7'b0000010;
  localparam logic [6:0] A = 7'b0000001;
  localparam logic [6:0] N = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, btn_up, btn_down, btn_left, btn_right, btn_enter, commit_ack;
  logic [14:0] player_name;
  logic [1:0]  input_pos;
  logic        active, commit_req, done;

  int total = 0;
  int bad   = 0;

  name_entry_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_enter  (btn_enter),
    .commit_ack (commit_ack),
    .player_name(player_name),
    .input_pos  (input_pos),
    .active     (active),
    .commit_req (commit_req),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  in;
    logic [14:0] name;
    logic [1:0]  pos;
    logic        act;
    logic        req;
    logic        dn;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [14:0] nm(input int a, input int b, input int c);
    return {5'(a), 5'(b), 5'(c)};
  endfunction

  function automatic vec_t mkv(input logic [6:0] in, input logic [14:0] name, input logic [1:0] pos,
                               input logic act, input logic req, input logic dn);
    vec_t v;
    v.in = in; v.name = name; v.pos = pos; v.act = act; v.req = req; v.dn = dn;
    return v;
  endfunction

  task automatic check(input string what, input logic [31:0] act_v, input logic [31:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", what, act_v, exp_v, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [14:0] name, input logic [1:0] pos,
                           input logic act, input logic req, input logic dn);
    check({tag, "_name"}, 32'(player_name), 32'(name));
    check({tag, "_pos"},  32'(input_pos),   32'(pos));
    check({tag, "_act"},  32'(active),      32'(act));
    check({tag, "_req"},  32'(commit_req),  32'(req));
    check({tag, "_done"}, 32'(done),        32'(dn));
  endtask

  // Apply one cycle of pulses, sample 1 time unit after the edge, then release
  task automatic drive(input logic [6:0] in);
    {start, btn_up, btn_down, btn_left, btn_right, btn_enter, commit_ack} = in;
    @(posedge clk);
    #1;
    {start, btn_up, btn_down, btn_left, btn_right, btn_enter, commit_ack} = N;
  endtask

  task automatic do_reset();
    {start, btn_up, btn_down, btn_left, btn_right, btn_enter, commit_ack} = N;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 15'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: mode 0 idle, 1 editing, 2 confirm slot, 3 waiting for storage
  int m_mode, m_pos, m_idle;
  int m_ch[3];
  bit m_done;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_idle = 0; m_done = 0;
    foreach (m_ch[i]) m_ch[i] = 0;
  endtask

  task automatic model_step(input logic [6:0] in);
    bit st, up, dn, lf, rt, en, ak, btn;
    {st, up, dn, lf, rt, en, ak} = in;
    btn    = up | dn | lf | rt | en;
    m_done = 0;
    if (m_mode == 0) begin
      if (st) begin
        m_mode = 1; m_pos = 0; m_idle = 0;
        foreach (m_ch[i]) m_ch[i] = 0;
      end
    end else if (m_mode == 3) begin
      if (ak) begin m_mode = 0; m_done = 1; end
    end else begin
      m_idle = btn ? 0 : m_idle + 1;
      if (m_mode == 1) begin
        if (en || rt) begin
          if (m_pos < 2) m_pos++;
          else begin m_mode = 2; m_pos = 3; end
        end else if (lf) begin
          if (m_pos > 0) m_pos--;
        end else if (up) m_ch[m_pos] = (m_ch[m_pos] + 1) % 26;
        else if (dn)     m_ch[m_pos] = (m_ch[m_pos] + 25) % 26;
      end else begin
        if (en) m_mode = 3;
        else if (lf) begin m_mode = 1; m_pos = 2; end
      end
      if (m_idle == TO) begin m_mode = 3; m_pos = 3; end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    {start, btn_up, btn_down, btn_left, btn_right, btn_enter, commit_ack} = N;
    #2;

    // Directed vectors: edit to "CZZ", confirm/back, commit handshake, priority, ignored inputs
    tbl.push_back(mkv(S, nm(0,0,0),   0, 1, 0, 0));
    tbl.push_back(mkv(U, nm(1,0,0),   0, 1, 0, 0));
    tbl.push_back(mkv(U, nm(2,0,0),   0, 1, 0, 0));
    tbl.push_back(mkv(R, nm(2,0,0),   1, 1, 0, 0));
    tbl.push_back(mkv(D, nm(2,25,0),  1, 1, 0, 0));
    tbl.push_back(mkv(R, nm(2,25,0),  2, 1, 0, 0));
    for (int k = 1; k <= 25; k++) tbl.push_back(mkv(U, nm(2,25,k), 2, 1, 0, 0));
    tbl.push_back(mkv(R, nm(2,25,25), 3, 1, 0, 0));
    tbl.push_back(mkv(L, nm(2,25,25), 2, 1, 0, 0));
    tbl.push_back(mkv(E, nm(2,25,25), 3, 1, 0, 0));
    tbl.push_back(mkv(E, nm(2,25,25), 3, 1, 1, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(mkv(N, nm(2,25,25), 3, 1, 1, 0));
    tbl.push_back(mkv(A, nm(2,25,25), 3, 0, 0, 1));
    tbl.push_back(mkv(N, nm(2,25,25), 3, 0, 0, 0));
    tbl.push_back(mkv(U|D|L|R|E, nm(2,25,25), 3, 0, 0, 0));
    tbl.push_back(mkv(A, nm(2,25,25), 3, 0, 0, 0));
    tbl.push_back(mkv(S, nm(0,0,0),   0, 1, 0, 0));
    tbl.push_back(mkv(U|R|L, nm(0,0,0), 1, 1, 0, 0));
    tbl.push_back(mkv(L, nm(0,0,0),   0, 1, 0, 0));
    tbl.push_back(mkv(L, nm(0,0,0),   0, 1, 0, 0));
    tbl.push_back(mkv(D, nm(25,0,0),  0, 1, 0, 0));
    tbl.push_back(mkv(U, nm(0,0,0),   0, 1, 0, 0));
    tbl.push_back(mkv(U, nm(1,0,0),   0, 1, 0, 0));
    tbl.push_back(mkv(S, nm(1,0,0),   0, 1, 0, 0));
    tbl.push_back(mkv(E, nm(1,0,0),   1, 1, 0, 0));
    tbl.push_back(mkv(E, nm(1,0,0),   2, 1, 0, 0));
    tbl.push_back(mkv(E, nm(1,0,0),   3, 1, 0, 0));
    tbl.push_back(mkv(R|U|D, nm(1,0,0), 3, 1, 0, 0));
    tbl.push_back(mkv(E, nm(1,0,0),   3, 1, 1, 0));
    tbl.push_back(mkv(S, nm(1,0,0),   3, 1, 1, 0));
    tbl.push_back(mkv(E|U|L, nm(1,0,0), 3, 1, 1, 0));
    tbl.push_back(mkv(A, nm(1,0,0),   3, 0, 0, 1));

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].in);
      check_all($sformatf("vec%0d", i), tbl[i].name, tbl[i].pos, tbl[i].act, tbl[i].req, tbl[i].dn);
    end

    // Timeout: auto-commit exactly TO cycles after the last button pulse
    drive(S);
    drive(U);
    for (int k = 1; k <= TO; k++) begin
      drive(N);
      if (k == TO - 1) check_all("to1_before", nm(1,0,0), 0, 1, 0, 0);
      if (k == TO)     check_all("to1_fire",   nm(1,0,0), 3, 1, 1, 0);
    end
    drive(A);
    check_all("to1_ack", nm(1,0,0), 3, 0, 0, 1);

    // A pulse partway through restarts the count
    drive(S);
    drive(U);
    for (int k = 1; k <= 9; k++) drive(N);
    drive(L);
    check_all("to2_restart", nm(1,0,0), 0, 1, 0, 0);
    for (int k = 1; k <= TO; k++) begin
      drive(N);
      if (k == TO - 1) check_all("to2_before", nm(1,0,0), 0, 1, 0, 0);
      if (k == TO)     check_all("to2_fire",   nm(1,0,0), 3, 1, 1, 0);
    end

    // Asynchronous reset while a commit is pending, sampled before the next clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 15'd0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] in;
      int burst;
      burst = ($urandom_range(39) == 0) ? TO + 4 : 1;
      for (int b = 0; b < burst; b++) begin
        in = N;
        if (burst == 1) begin
          in[6] = ($urandom_range(7) == 0);
          for (int j = 1; j <= 5; j++) in[j] = ($urandom_range(5) == 0);
          in[0] = ($urandom_range(3) == 0);
        end
        drive(in);
        model_step(in);
        check_all($sformatf("rnd%0d", n), nm(m_ch[0], m_ch[1], m_ch[2]), 2'(m_pos),
                  m_mode != 0, m_mode == 3, m_done);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
